// File: rtl/buf_token_sched_pkg.sv
// Shared token definitions for the packet-buffer token scheduler.
// Tokens 1..NUM_TOK name physical packet buffers; TOK_NONE marks "no buffer held".
package bufsched_pkg;

    localparam int TOK_W   = 2;
    localparam int NUM_TOK = 3;

    typedef logic [TOK_W-1:0] tok_t;

    localparam tok_t TOK_NONE = '0;

endpackage

// File: rtl/buf_token_sched_if.sv
// Agent-side bundle of the token scheduler: snooper, filter CPUs, forwarder.
// The agents form the master side; the scheduler is the slave.
interface buf_token_sched_if #(
    parameter int NUM_CPUS = 2
);
    import bufsched_pkg::*;

    logic                      sn_req;
    logic                      sn_gnt;
    tok_t                      sn_tok;
    logic                      sn_done;
    logic [NUM_CPUS-1:0]       cpu_req;
    logic [NUM_CPUS-1:0]       cpu_gnt;
    logic [TOK_W*NUM_CPUS-1:0] cpu_tok;
    logic [NUM_CPUS-1:0]       cpu_acc;
    logic [NUM_CPUS-1:0]       cpu_rej;
    logic [NUM_CPUS-1:0]       cpu_vack;
    tok_t                      fwd_tok;
    logic                      fwd_done;
    logic [31:0]               stat_acc;
    logic [31:0]               stat_rej;

    modport master (
        output sn_req, sn_done, cpu_req, cpu_acc, cpu_rej, fwd_done,
        input  sn_gnt, sn_tok, cpu_gnt, cpu_tok, cpu_vack, fwd_tok, stat_acc, stat_rej
    );

    modport slave (
        input  sn_req, sn_done, cpu_req, cpu_acc, cpu_rej, fwd_done,
        output sn_gnt, sn_tok, cpu_gnt, cpu_tok, cpu_vack, fwd_tok, stat_acc, stat_rej
    );

endinterface

// File: rtl/buf_token_sched_tok_fifo.sv
// Three-entry token FIFO with one pop and two ordered push ports (push0 lands first).
// Entry 0 is the registered head; unused entries are held at TOK_NONE so an empty head reads 0.
module tok_fifo
    import bufsched_pkg::*;
#(
    parameter bit INIT_FULL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pop,
    input  logic push0_en,
    input  tok_t push0,
    input  logic push1_en,
    input  tok_t push1,
    output tok_t head
);

    localparam logic [1:0] DEPTH = 2'(NUM_TOK);

    tok_t       mem_q [NUM_TOK];
    tok_t       mem_d [NUM_TOK];
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Pop shifts first so pushes append behind whatever remains this cycle.
    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop && cnt_q != 2'd0) begin
            for (int i = 0; i < NUM_TOK - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[NUM_TOK - 1] = TOK_NONE;
            cnt_d = cnt_q - 2'd1;
        end
        if (push0_en && cnt_d != DEPTH) begin
            mem_d[cnt_d] = push0;
            cnt_d        = cnt_d + 2'd1;
        end
        if (push1_en && cnt_d != DEPTH) begin
            mem_d[cnt_d] = push1;
            cnt_d        = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TOK; i++) begin
                mem_q[i] <= INIT_FULL ? tok_t'(i + 1) : TOK_NONE;
            end
            cnt_q <= INIT_FULL ? DEPTH : 2'd0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign head = mem_q[0];

endmodule

// File: rtl/buf_token_sched.sv
// Packet-buffer token scheduler: free/ready/forward queues, round-robin CPU grant, verdict handling.
// Define BUFSCHED_STATS_EN to build the accept/reject verdict counters; otherwise they read 0.
module buf_token_sched
    import bufsched_pkg::*;
#(
    parameter int NUM_CPUS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    buf_token_sched_if.slave bus
);

    localparam int PTR_W = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

    tok_t                sn_tok_q, sn_tok_d;
    logic                sn_gnt_q, sn_gnt_d;
    tok_t                cpu_tok_q [NUM_CPUS];
    tok_t                cpu_tok_d [NUM_CPUS];
    logic [NUM_CPUS-1:0] cpu_gnt_q, cpu_gnt_d;
    logic [NUM_CPUS-1:0] cpu_vack_q, cpu_vack_d;
    logic [PTR_W-1:0]    rr_q, rr_d;
    logic [NUM_CPUS-1:0] eligible, gnt_vec;
    logic                gnt_found, vack_found;

    tok_t free_head, ready_head, fwd_head;
    logic free_pop, free_push0_en, free_push1_en;
    tok_t free_push0, free_push1;
    logic ready_pop, ready_push_en;
    tok_t ready_push;
    logic fwd_pop, fwd_push_en;
    tok_t fwd_push;

    tok_fifo #(.INIT_FULL(1'b1)) u_free (
        .clk(clk), .rst_n(rst_n), .pop(free_pop),
        .push0_en(free_push0_en), .push0(free_push0),
        .push1_en(free_push1_en), .push1(free_push1),
        .head(free_head)
    );

    tok_fifo #(.INIT_FULL(1'b0)) u_ready (
        .clk(clk), .rst_n(rst_n), .pop(ready_pop),
        .push0_en(ready_push_en), .push0(ready_push),
        .push1_en(1'b0), .push1(TOK_NONE),
        .head(ready_head)
    );

    tok_fifo #(.INIT_FULL(1'b0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .pop(fwd_pop),
        .push0_en(fwd_push_en), .push0(fwd_push),
        .push1_en(1'b0), .push1(TOK_NONE),
        .head(fwd_head)
    );

    always_comb begin
        sn_tok_d      = sn_tok_q;
        sn_gnt_d      = 1'b0;
        cpu_tok_d     = cpu_tok_q;
        cpu_gnt_d     = '0;
        cpu_vack_d    = '0;
        rr_d          = rr_q;
        eligible      = '0;
        gnt_vec       = '0;
        gnt_found     = 1'b0;
        vack_found    = 1'b0;
        free_pop      = 1'b0;
        free_push0_en = 1'b0;
        free_push0    = TOK_NONE;
        free_push1_en = 1'b0;
        free_push1    = TOK_NONE;
        ready_pop     = 1'b0;
        ready_push_en = 1'b0;
        ready_push    = TOK_NONE;
        fwd_pop       = 1'b0;
        fwd_push_en   = 1'b0;
        fwd_push      = TOK_NONE;

        if (bus.sn_req && sn_tok_q == TOK_NONE && free_head != TOK_NONE) begin
            free_pop = 1'b1;
            sn_tok_d = free_head;
            sn_gnt_d = 1'b1;
        end
        if (bus.sn_done && sn_tok_q != TOK_NONE) begin
            ready_push_en = 1'b1;
            ready_push    = sn_tok_q;
            sn_tok_d      = TOK_NONE;
        end
        // Forwarded token takes push0 so it re-enters the free list ahead of a same-cycle reject.
        if (bus.fwd_done && fwd_head != TOK_NONE) begin
            fwd_pop       = 1'b1;
            free_push0_en = 1'b1;
            free_push0    = fwd_head;
        end

        for (int i = 0; i < NUM_CPUS; i++) begin
            eligible[i] = bus.cpu_req[i] && (cpu_tok_q[i] == TOK_NONE);
        end
        // Round robin as two passes: at/after the pointer first, then wrap from index 0.
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (!gnt_found && eligible[i] && i >= int'(rr_q)) begin
                gnt_found  = 1'b1;
                gnt_vec[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (!gnt_found && eligible[i]) begin
                gnt_found  = 1'b1;
                gnt_vec[i] = 1'b1;
            end
        end
        if (ready_head != TOK_NONE) begin
            for (int i = 0; i < NUM_CPUS; i++) begin
                if (gnt_vec[i]) begin
                    ready_pop    = 1'b1;
                    cpu_tok_d[i] = ready_head;
                    cpu_gnt_d[i] = 1'b1;
                    rr_d         = (i == NUM_CPUS - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end

        // A granted CPU held no token, so it can never also be the verdict winner here.
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (!vack_found && cpu_tok_q[i] != TOK_NONE && (bus.cpu_acc[i] || bus.cpu_rej[i])) begin
                vack_found    = 1'b1;
                cpu_vack_d[i] = 1'b1;
                cpu_tok_d[i]  = TOK_NONE;
                if (bus.cpu_rej[i]) begin
                    free_push1_en = 1'b1;
                    free_push1    = cpu_tok_q[i];
                end else begin
                    fwd_push_en = 1'b1;
                    fwd_push    = cpu_tok_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sn_tok_q   <= TOK_NONE;
            sn_gnt_q   <= 1'b0;
            cpu_gnt_q  <= '0;
            cpu_vack_q <= '0;
            rr_q       <= '0;
            for (int i = 0; i < NUM_CPUS; i++) begin
                cpu_tok_q[i] <= TOK_NONE;
            end
        end else begin
            sn_tok_q   <= sn_tok_d;
            sn_gnt_q   <= sn_gnt_d;
            cpu_gnt_q  <= cpu_gnt_d;
            cpu_vack_q <= cpu_vack_d;
            rr_q       <= rr_d;
            cpu_tok_q  <= cpu_tok_d;
        end
    end

    assign bus.sn_gnt   = sn_gnt_q;
    assign bus.sn_tok   = sn_tok_q;
    assign bus.cpu_gnt  = cpu_gnt_q;
    assign bus.cpu_vack = cpu_vack_q;
    assign bus.fwd_tok  = fwd_head;

    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_cpu_tok
        assign bus.cpu_tok[TOK_W*g +: TOK_W] = cpu_tok_q[g];
    end

`ifdef BUFSCHED_STATS_EN
    logic [31:0] stat_acc_q, stat_rej_q;

    // The one-hot vack identifies the consumed verdict; rej wins when both were raised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_acc_q <= '0;
            stat_rej_q <= '0;
        end else begin
            if (|(cpu_vack_d & ~bus.cpu_rej)) stat_acc_q <= stat_acc_q + 32'd1;
            if (|(cpu_vack_d & bus.cpu_rej))  stat_rej_q <= stat_rej_q + 32'd1;
        end
    end

    assign bus.stat_acc = stat_acc_q;
    assign bus.stat_rej = stat_rej_q;
`else
    assign bus.stat_acc = '0;
    assign bus.stat_rej = '0;
`endif

endmodule

// File: tb/tb_buf_token_sched.sv
// Directed bench for buf_token_sched with two CPUs; expectations are hand-traced token movements.
// Counter expectations follow BUFSCHED_STATS_EN when the bench is compiled with it.
module tb_buf_token_sched;
    import bufsched_pkg::*;

    localparam int NUM_CPUS = 2;

`ifdef BUFSCHED_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    buf_token_sched_if #(.NUM_CPUS(NUM_CPUS)) bus ();

    buf_token_sched #(.NUM_CPUS(NUM_CPUS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic sn_req, input logic sn_done,
                                 input logic [1:0] cpu_req, input logic [1:0] cpu_acc,
                                 input logic [1:0] cpu_rej, input logic fwd_done);
        bus.sn_req   = sn_req;
        bus.sn_done  = sn_done;
        bus.cpu_req  = cpu_req;
        bus.cpu_acc  = cpu_acc;
        bus.cpu_rej  = cpu_rej;
        bus.fwd_done = fwd_done;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("rst_sn_tok",  32'(bus.sn_tok), 0);
        checkOutput("rst_sn_gnt",  32'(bus.sn_gnt), 0);
        checkOutput("rst_cpu_tok", 32'(bus.cpu_tok), 0);
        checkOutput("rst_fwd_tok", 32'(bus.fwd_tok), 0);
        checkOutput("rst_vack",    32'(bus.cpu_vack), 0);
        rst_n = 1'b1;

        // Snooper takes the free list in order, handing each to the ready queue.
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_gnt_first", 32'(bus.sn_gnt), 1);
        checkOutput("sn_tok_first", 32'(bus.sn_tok), 1);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_tok_done",  32'(bus.sn_tok), 0);
        checkOutput("sn_gnt_pulse", 32'(bus.sn_gnt), 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_tok_second", 32'(bus.sn_tok), 2);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_tok_third", 32'(bus.sn_tok), 3);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_gnt_free_empty", 32'(bus.sn_gnt), 0);
        checkOutput("sn_tok_free_empty", 32'(bus.sn_tok), 0);

        // Ready = {1,2,3}; both CPUs request continuously.
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("rr_gnt_cpu0", 32'(bus.cpu_gnt), 32'h1);
        checkOutput("rr_tok_cpu0", 32'(bus.cpu_tok), 32'h1);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("rr_gnt_cpu1", 32'(bus.cpu_gnt), 32'h2);
        checkOutput("rr_tok_cpu1", 32'(bus.cpu_tok), 32'h9);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("no_gnt_holding", 32'(bus.cpu_gnt), 0);
        checkOutput("tok_kept_holding", 32'(bus.cpu_tok), 32'h9);

        // CPU0 accepts and CPU1 rejects together: CPU0 wins, CPU1 holds its verdict.
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0);
        checkOutput("vack_cpu0",      32'(bus.cpu_vack), 32'h1);
        checkOutput("fwd_tok_accept", 32'(bus.fwd_tok), 1);
        checkOutput("cpu_tok_after0", 32'(bus.cpu_tok), 32'h8);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
        checkOutput("vack_cpu1",      32'(bus.cpu_vack), 32'h2);
        checkOutput("cpu_tok_after1", 32'(bus.cpu_tok), 0);
        checkOutput("fwd_tok_held",   32'(bus.fwd_tok), 1);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("vack_pulse", 32'(bus.cpu_vack), 0);

        // Free = {2}, ready = {3}, fwd = {1}: drain free and ready, then fwd_done + reject together.
        applyStimulus(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_tok_two",   32'(bus.sn_tok), 2);
        checkOutput("cpu0_tok_three", 32'(bus.cpu_tok), 32'h3);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1);
        checkOutput("vack_rej_fwd", 32'(bus.cpu_vack), 32'h1);
        checkOutput("fwd_tok_drained", 32'(bus.fwd_tok), 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("free_order_fwd_first", 32'(bus.sn_tok), 1);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("free_order_rej_second", 32'(bus.sn_tok), 3);

        // Ready = {2,1}, pointer at CPU1; snooper holds 3 so its request is not granted.
        applyStimulus(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("rr_from_ptr1", 32'(bus.cpu_gnt), 32'h2);
        checkOutput("cpu1_tok_two", 32'(bus.cpu_tok), 32'h8);
        checkOutput("sn_no_gnt_holding", 32'(bus.sn_gnt), 0);
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("cpu_tok_all_held", 32'(bus.cpu_tok), 32'h9);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_starved", 32'(bus.sn_gnt), 0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0);
        checkOutput("sn_no_bypass", 32'(bus.sn_gnt), 0);
        checkOutput("vack_free_one", 32'(bus.cpu_vack), 32'h1);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("sn_gnt_after_free", 32'(bus.sn_gnt), 1);
        checkOutput("sn_tok_after_free", 32'(bus.sn_tok), 1);

        // acc and rej together count as reject; a verdict without a token is ignored.
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 1'b0);
        checkOutput("accrej_vack", 32'(bus.cpu_vack), 32'h2);
        checkOutput("accrej_no_fwd", 32'(bus.fwd_tok), 0);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
        checkOutput("verdict_no_tok", 32'(bus.cpu_vack), 0);
        checkOutput("stat_acc", bus.stat_acc, STATS_ON ? 32'd1 : 32'd0);
        checkOutput("stat_rej", bus.stat_rej, STATS_ON ? 32'd4 : 32'd0);

        // Pointer at CPU1 again; ready = {3}.
        applyStimulus(1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0);
        checkOutput("rr_cpu1_again", 32'(bus.cpu_gnt), 32'h2);
        checkOutput("cpu1_tok_three", 32'(bus.cpu_tok), 32'hC);
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0);
        checkOutput("fwd_tok_three", 32'(bus.fwd_tok), 3);

        // Mid-flow reset with every input active.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 1'b1);
        checkOutput("mid_rst_sn_tok",  32'(bus.sn_tok), 0);
        checkOutput("mid_rst_sn_gnt",  32'(bus.sn_gnt), 0);
        checkOutput("mid_rst_cpu_tok", 32'(bus.cpu_tok), 0);
        checkOutput("mid_rst_cpu_gnt", 32'(bus.cpu_gnt), 0);
        checkOutput("mid_rst_vack",    32'(bus.cpu_vack), 0);
        checkOutput("mid_rst_fwd_tok", 32'(bus.fwd_tok), 0);
        checkOutput("mid_rst_stat_acc", bus.stat_acc, 0);
        checkOutput("mid_rst_stat_rej", bus.stat_rej, 0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("post_rst_tok1", 32'(bus.sn_tok), 1);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("post_rst_tok2", 32'(bus.sn_tok), 2);
        applyStimulus(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("post_rst_tok3", 32'(bus.sn_tok), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
